// File: rtl/i2c_slave_regs_if.sv
// i2c_slave_regs_if: I2C pin levels plus host register-bank strobes for i2c_slave_regs.
interface i2c_slave_regs_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_stb;
    logic [7:0] wr_idx;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_idx;
    logic [7:0] rd_data;
    logic       busy;
    modport slave (
        input  scl_in, sda_in, rd_data,
        output sda_oe, wr_stb, wr_idx, wr_data, rd_req, rd_idx, busy
    );
    modport master (
        output scl_in, sda_in, rd_data,
        input  sda_oe, wr_stb, wr_idx, wr_data, rd_req, rd_idx, busy
    );
endinterface

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: oversampling I2C target with index pointer, write strobes and read prefetch requests.
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input logic            clk,
    input logic            rst_n,
    i2c_slave_regs_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, INDEX, INDEX_ACK, WDATA, WDATA_ACK, RDATA, MACK, WAIT, IGNORE
    } state_t;

    state_t     state, state_n;
    logic [2:0] scl_q, sda_q;
    logic       fall_q;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] ptr, ptr_n;
    logic       rw, rw_n;
    logic       hit, hit_n;
    logic       busy, busy_n;
    logic       wr_stb, wr_stb_n;
    logic [7:0] wr_idx, wr_idx_n;
    logic [7:0] wr_data, wr_data_n;
    logic       rd_req, rd_req_n;
    logic [7:0] rd_idx, rd_idx_n;
    logic       sda_oe, sda_oe_n;
    logic       rise, fall, start, stop, drive;
    logic [7:0] byte_in;

    assign rise    = scl_q[1] & ~scl_q[2];
    assign fall    = ~scl_q[1] & scl_q[2];
    assign start   = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign stop    = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    assign byte_in = {shift[6:0], sda_q[1]};
    // ACK states pull low for the whole 9th bit; RDATA pulls low for a 0 data bit
    assign drive   = (state == ADDR_ACK) | (state == INDEX_ACK) | (state == WDATA_ACK) |
                     ((state == RDATA) & ~shift[7]);

    assign bus.sda_oe  = sda_oe;
    assign bus.wr_stb  = wr_stb;
    assign bus.wr_idx  = wr_idx;
    assign bus.wr_data = wr_data;
    assign bus.rd_req  = rd_req;
    assign bus.rd_idx  = rd_idx;
    assign bus.busy    = busy;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            scl_q   <= 3'b111;
            sda_q   <= 3'b111;
            fall_q  <= 1'b0;
            state   <= IDLE;
            cnt     <= 4'd0;
            shift   <= 8'd0;
            ptr     <= 8'd0;
            rw      <= 1'b0;
            hit     <= 1'b0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_idx  <= 8'd0;
            wr_data <= 8'd0;
            rd_req  <= 1'b0;
            rd_idx  <= 8'd0;
            sda_oe  <= 1'b0;
        end else begin
            scl_q   <= {scl_q[1:0], bus.scl_in};
            sda_q   <= {sda_q[1:0], bus.sda_in};
            fall_q  <= fall;
            state   <= state_n;
            cnt     <= cnt_n;
            shift   <= shift_n;
            ptr     <= ptr_n;
            rw      <= rw_n;
            hit     <= hit_n;
            busy    <= busy_n;
            wr_stb  <= wr_stb_n;
            wr_idx  <= wr_idx_n;
            wr_data <= wr_data_n;
            rd_req  <= rd_req_n;
            rd_idx  <= rd_idx_n;
            sda_oe  <= sda_oe_n;
        end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shift_n   = rd_req ? bus.rd_data : shift;
        ptr_n     = ptr;
        rw_n      = rw;
        hit_n     = hit;
        busy_n    = busy;
        wr_stb_n  = 1'b0;
        wr_idx_n  = wr_idx;
        wr_data_n = wr_data;
        rd_req_n  = 1'b0;
        rd_idx_n  = rd_idx;
        // bits land on SCL rise, state moves on SCL fall
        if (start) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            busy_n  = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            busy_n  = 1'b0;
        end else if (rise) begin
            case (state)
                ADDR, INDEX, WDATA: begin
                    shift_n = byte_in;
                    cnt_n   = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        if (state == ADDR) begin
                            hit_n = shift[6:0] == DEV_ADDR;
                            rw_n  = sda_q[1];
                        end else if (state == INDEX) begin
                            ptr_n = byte_in;
                        end else begin
                            wr_stb_n  = 1'b1;
                            wr_idx_n  = ptr;
                            wr_data_n = byte_in;
                            ptr_n     = ptr + 8'd1;
                        end
                    end
                end
                ADDR_ACK: begin
                    rd_req_n = rw;
                    rd_idx_n = rw ? ptr : rd_idx;
                end
                RDATA: cnt_n = cnt + 4'd1;
                MACK: begin
                    hit_n    = ~sda_q[1];
                    rd_req_n = ~sda_q[1];
                    rd_idx_n = sda_q[1] ? rd_idx : ptr;
                end
                default: ;
            endcase
        end else if (fall) begin
            case (state)
                ADDR: begin
                    state_n = cnt == 4'd8 ? (hit ? ADDR_ACK : IGNORE) : ADDR;
                    busy_n  = cnt == 4'd8 ? hit : busy;
                end
                INDEX: state_n = cnt == 4'd8 ? INDEX_ACK : INDEX;
                WDATA: state_n = cnt == 4'd8 ? WDATA_ACK : WDATA;
                ADDR_ACK: begin
                    state_n = rw ? RDATA : INDEX;
                    cnt_n   = 4'd0;
                end
                INDEX_ACK, WDATA_ACK: begin
                    state_n = WDATA;
                    cnt_n   = 4'd0;
                end
                RDATA: begin
                    state_n = cnt == 4'd8 ? MACK : RDATA;
                    ptr_n   = cnt == 4'd8 ? ptr + 8'd1 : ptr;
                    shift_n = cnt == 4'd8 ? shift : {shift[6:0], 1'b0};
                end
                MACK: begin
                    state_n = hit ? RDATA : WAIT;
                    cnt_n   = 4'd0;
                    busy_n  = hit;
                end
                default: ;
            endcase
        end
        sda_oe_n = (start | stop) ? 1'b0 : fall_q ? drive : sda_oe;
    end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: directed I2C master transactions against i2c_slave_regs with an inverting host bank.
module tb_i2c_slave_regs;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [15:0] wrq[$];
    logic [7:0]  rdq[$];
    int   oe_cnt = 0;
    int   busy_cnt = 0;

    i2c_slave_regs_if bus();
    assign bus.scl_in  = scl;
    assign bus.sda_in  = sda_m & ~bus.sda_oe;
    assign bus.rd_data = ~bus.rd_idx;

    i2c_slave_regs #(.DEV_ADDR(7'h50)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_stb) wrq.push_back({bus.wr_idx, bus.wr_data});
        if (bus.rd_req) rdq.push_back(bus.rd_idx);
        if (bus.sda_oe) oe_cnt++;
        if (bus.busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sbit(input logic b, output logic r);
        wait_clk(4);
        sda_m = b;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        r = bus.sda_in;
        wait_clk(4);
        scl = 1'b0;
    endtask

    task automatic start_c;
        sda_m = 1'b1;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl = 1'b0;
    endtask

    task automatic stop_c;
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(4);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) sbit(d[i], r);
        sbit(1'b1, r);
        ack = ~r;
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            sbit(1'b1, r);
            d[i] = r;
        end
        sbit(nack, r);
    endtask

    initial begin
        logic a0, a1, a2, a3;
        logic [7:0] d0, d1, d2;
        int wb, rb, ob, bb;
        wait_clk(3);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_wr_stb", bus.wr_stb, 0);
        chk("rst_rd_req", bus.rd_req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wr_idx", bus.wr_idx, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_rd_idx", bus.rd_idx, 0);
        rst_n = 1'b1;
        wait_clk(6);

        start_c;
        wbyte(8'hA0, a0);
        wbyte(8'h10, a1);
        wbyte(8'hA5, a2);
        wbyte(8'h3C, a3);
        chk("wr_busy_mid", bus.busy, 1);
        stop_c;
        wait_clk(6);
        chk("wr_acks", {28'd0, a0, a1, a2, a3}, 32'hF);
        chk("wr_count", wrq.size(), 2);
        chk("wr_first", wrq[0], 16'h10A5);
        chk("wr_second", wrq[1], 16'h113C);
        chk("wr_busy_end", bus.busy, 0);
        wb = wrq.size(); rb = rdq.size(); ob = oe_cnt;
        repeat (3) begin
            wait_clk(4); scl = 1'b0;
            wait_clk(4); scl = 1'b1;
        end
        wait_clk(6);
        chk("trail_wr", wrq.size(), wb);
        chk("trail_rd", rdq.size(), rb);
        chk("trail_oe", oe_cnt, ob);

        start_c;
        wbyte(8'hA0, a0);
        wbyte(8'h20, a1);
        start_c;
        wbyte(8'hA1, a2);
        rbyte(1'b0, d0);
        rbyte(1'b0, d1);
        rbyte(1'b1, d2);
        wait_clk(6);
        chk("rd_oe_after_nack", bus.sda_oe, 0);
        chk("rd_busy_after_nack", bus.busy, 0);
        stop_c;
        wait_clk(6);
        chk("rd_acks", {29'd0, a0, a1, a2}, 32'h7);
        chk("rd_byte0", d0, 8'hDF);
        chk("rd_byte1", d1, 8'hDE);
        chk("rd_byte2", d2, 8'hDD);
        chk("rd_req_count", rdq.size() - rb, 3);
        chk("rd_req0", rdq[rb], 8'h20);
        chk("rd_req1", rdq[rb + 1], 8'h21);
        chk("rd_req2", rdq[rb + 2], 8'h22);
        chk("rd_ptr", dut.ptr, 8'h23);

        wb = wrq.size(); rb = rdq.size(); ob = oe_cnt; bb = busy_cnt;
        start_c;
        wbyte(8'hA2, a0);
        wbyte(8'h33, a1);
        stop_c;
        wait_clk(6);
        chk("nomatch_ack", a0, 0);
        chk("nomatch_wr", wrq.size(), wb);
        chk("nomatch_rd", rdq.size(), rb);
        chk("nomatch_oe", oe_cnt, ob);
        chk("nomatch_busy", busy_cnt, bb);

        wb = wrq.size();
        start_c;
        wbyte(8'hA0, a0);
        wbyte(8'hFF, a1);
        wbyte(8'h11, a2);
        wbyte(8'h22, a3);
        stop_c;
        wait_clk(6);
        chk("wrap_count", wrq.size() - wb, 2);
        chk("wrap_first", wrq[wb], 16'hFF11);
        chk("wrap_second", wrq[wb + 1], 16'h0022);

        wb = wrq.size();
        start_c;
        wbyte(8'hA0, a0);
        wbyte(8'h40, a1);
        wbyte(8'h77, a2);
        for (int i = 0; i < 4; i++) sbit(1'b1, a3);
        stop_c;
        wait_clk(6);
        chk("part_count", wrq.size() - wb, 1);
        chk("part_first", wrq[wb], 16'h4077);
        chk("part_state_idle", 32'(dut.state), 0);
        start_c;
        wbyte(8'hA0, a0);
        wbyte(8'h50, a1);
        wbyte(8'h99, a2);
        stop_c;
        wait_clk(6);
        chk("part_next_acks", {29'd0, a0, a1, a2}, 32'h7);
        chk("part_next_count", wrq.size() - wb, 2);
        chk("part_next_wr", wrq[wb + 1], 16'h5099);

        start_c;
        wbyte(8'hA0, a0);
        wbyte(8'h80, a1);
        start_c;
        wbyte(8'hA1, a2);
        wait_clk(6);
        chk("rst_pre_oe", bus.sda_oe, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_oe", bus.sda_oe, 0);
        chk("rst_ptr", dut.ptr, 0);
        wait_clk(3);
        rst_n = 1'b1;
        scl = 1'b1;
        sda_m = 1'b1;
        wait_clk(6);
        wb = wrq.size();
        start_c;
        wbyte(8'hA0, a0);
        wbyte(8'h05, a1);
        wbyte(8'h66, a2);
        stop_c;
        wait_clk(6);
        chk("post_rst_acks", {29'd0, a0, a1, a2}, 32'h7);
        chk("post_rst_count", wrq.size() - wb, 1);
        chk("post_rst_wr", wrq[wb], 16'h0566);
        chk("post_rst_ptr", dut.ptr, 8'h06);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
